// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Collects DEPTH operand pairs (A, B) from a producer, then streams them
//   one pair per cycle into the downstream multiply-accumulate unit.
//   A 2-bit state code (FILL=0, EXEC=1, DONE=2) and a done flag let board
//   logic wait for the run to finish before reading the accumulator.
//
// Ports
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   start     one-cycle pulse, restarts a run from DONE (ignored elsewhere)
//   stall     downstream back-pressure, pauses draining in EXEC
//   in_valid  producer offers in_a/in_b this cycle
//   in_a/in_b operand pair from the producer
//   in_ready  sequencer accepts a pair this cycle (combinational)
//   mac_en    mac_a/mac_b valid, MAC accumulates this cycle
//   mac_clr   one-cycle accumulator clear after reset and on restart
//   mac_a/b   registered operands to the MAC
//   state     0=FILL, 1=EXEC, 2=DONE
//   done      high while in DONE
//   fill_cnt  pairs currently buffered
module mac_operand_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  in_ready,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic [1:0]            state,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  fill_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   rd_ptr;
  logic [DATA_WIDTH-1:0]  mem_a [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_b [DEPTH];
  logic                   hs;

  assign in_ready = (state_q == S_FILL) && (fill_cnt < FULL);
  assign hs       = in_valid && in_ready;
  assign state    = state_q;
  assign done     = (state_q == S_DONE);

  // NOTE: the operand arrays carry no reset; stale contents are harmless
  // because fill_cnt/rd_ptr restart at zero and every entry is rewritten
  // before it is read. Leaving memories unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (!rst && hs) begin
      mem_a[fill_cnt[AW-1:0]] <= in_a;
      mem_b[fill_cnt[AW-1:0]] <= in_b;
    end
  end

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values; blocking here would let later lines
  // see this cycle's updates and break the one-cycle operand latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FILL;
      fill_cnt <= '0;
      rd_ptr   <= '0;
      mac_en   <= 1'b0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_clr  <= 1'b1;
    end else begin
      // Strobes default low; each branch raises them only when needed.
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      unique case (state_q)
        S_FILL: begin
          // The full cycle stays in FILL with in_ready low, so a pair
          // offered while full is simply not accepted.
          if (fill_cnt == FULL) begin
            state_q <= S_EXEC;
          end else if (hs) begin
            fill_cnt <= fill_cnt + ONE;
          end
        end
        S_EXEC: begin
          // Stall wins over the pop: pointer and operands hold.
          if (!stall) begin
            mac_a  <= mem_a[rd_ptr[AW-1:0]];
            mac_b  <= mem_b[rd_ptr[AW-1:0]];
            mac_en <= 1'b1;
            rd_ptr <= rd_ptr + ONE;
            if (rd_ptr == LAST) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Restart takes priority over any pair offered this cycle; it is
          // not captured because in_ready is low outside FILL.
          if (start) begin
            fill_cnt <= '0;
            rd_ptr   <= '0;
            mac_clr  <= 1'b1;
            state_q  <= S_FILL;
          end
        end
        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          in_ready;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [1:0]    state;
  logic          done;
  logic [CW-1:0] fill_cnt;

  mac_operand_sequencer #(.DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stall    (stall),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ready (in_ready),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .state    (state),
    .done     (done),
    .fill_cnt (fill_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Bench-side MAC model: accumulates every mac_en cycle on the falling edge.
  int acc = 0;
  int pulses = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int got_a[$];
  int got_b[$];

  always @(negedge clk) begin
    cyc++;
    if (mac_en) begin
      acc += int'(mac_a) * int'(mac_b);
      if (pulses == 0) first_cyc = cyc;
      last_cyc = cyc;
      pulses++;
      got_a.push_back(int'(mac_a));
      got_b.push_back(int'(mac_b));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_model();
    acc = 0;
    pulses = 0;
    got_a.delete();
    got_b.delete();
  endtask

  function automatic int exp_a(input int mode, input int k);
    case (mode)
      1:       return 10 * (k + 1);
      2:       return 2;
      default: return k + 1;
    endcase
  endfunction

  function automatic int exp_b(input int mode, input int k);
    return (mode == 2) ? 2 : k + 1;
  endfunction

  // mode 0: A=B=i, mode 1: gapped A=10i B=i, mode 2: A=B=2.
  // start_at pulses start alongside pair number start_at (0 = never).
  task automatic load(input int mode, input int start_at);
    for (int i = 1; i <= D; i++) begin
      if (mode == 1) begin
        in_valid = 1'b0;
        tick();
        check("gap_hold_cnt", int'(fill_cnt), i - 1);
        check("gap_hold_state", int'(state), 0);
      end
      in_valid = 1'b1;
      in_a  = DW'(exp_a(mode, i - 1));
      in_b  = DW'(exp_b(mode, i - 1));
      start = (i == start_at);
      tick();
      check("fill_cnt", int'(fill_cnt), i);
    end
    start = 1'b0;
    check("full_state", int'(state), 0);
    check("full_in_ready", int'(in_ready), 0);
    // Offer a pair while full; it must not be stored or counted.
    in_valid = 1'b1;
    in_a = 8'hEE;
    in_b = 8'hEE;
  endtask

  // Stall on EXEC cycles s0/s1 (0-based), pulse start on EXEC cycle st.
  task automatic drain(input int s0, input int s1, input int st, input int last_a);
    int e = 0;
    bit ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      stall = (state == 2'd1) && (e == s0 || e == s1);
      start = (state == 2'd1) && (e == st);
      if (state == 2'd1) e++;
      tick();
      in_valid = 1'b0;
      stall = 1'b0;
      start = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_reached_done", int'(ok), 1);
    check("last_pulse_en", int'(mac_en), 1);
    check("last_pulse_a", int'(mac_a), last_a);
    tick();
    check("done_mac_en", int'(mac_en), 0);
    check("done_flag", int'(done), 1);
    check("done_state", int'(state), 2);
    check("done_in_ready", int'(in_ready), 0);
  endtask

  task automatic verify(input int mode, input int span, input int sum);
    check("pulse_count", pulses, D);
    check("acc_sum", acc, sum);
    check("pulse_span", last_cyc - first_cyc, span);
    for (int k = 0; k < D; k++) begin
      check("pair_a", (k < got_a.size()) ? got_a[k] : -1, exp_a(mode, k));
      check("pair_b", (k < got_b.size()) ? got_b[k] : -1, exp_b(mode, k));
    end
  endtask

  // Restart from DONE with a pair offered in the same cycle.
  task automatic restart();
    start = 1'b1;
    in_valid = 1'b1;
    in_a = 8'd77;
    in_b = 8'd77;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check("restart_clr", int'(mac_clr), 1);
    check("restart_state", int'(state), 0);
    check("restart_cnt", int'(fill_cnt), 0);
    check("restart_done", int'(done), 0);
    check("restart_ready", int'(in_ready), 1);
    tick();
    check("restart_clr_drop", int'(mac_clr), 0);
    check("restart_no_capture", int'(fill_cnt), 0);
    reset_model();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    check("rst_state", int'(state), 0);
    check("rst_cnt", int'(fill_cnt), 0);
    check("rst_mac_en", int'(mac_en), 0);
    check("rst_mac_a", int'(mac_a), 0);
    check("rst_mac_b", int'(mac_b), 0);
    check("rst_done", int'(done), 0);
    check("rst_clr", int'(mac_clr), 1);
    rst = 1'b0;
    tick();
    check("rst_clr_drop", int'(mac_clr), 0);
    check("rst_ready", int'(in_ready), 1);

    // Run 1: plain load 1..8, start pulsed during FILL and EXEC
    reset_model();
    load(0, 3);
    drain(-1, -1, 1, 8);
    verify(0, 7, 204);

    // Run 2: stall on EXEC cycles 3 and 4
    restart();
    load(0, 0);
    drain(2, 3, -1, 8);
    verify(0, 9, 204);

    // Run 3: gapped producer, A=10i, B=i
    restart();
    load(1, 0);
    drain(-1, -1, -1, 80);
    verify(1, 7, 2040);

    // Run 4: A=B=2
    restart();
    load(2, 0);
    drain(-1, -1, -1, 2);
    verify(2, 7, 32);

    // Run 5: reset after 4 pops, then a fresh run
    restart();
    load(0, 0);
    for (int c = 0; c < 30; c++) begin
      tick();
      in_valid = 1'b0;
      if (pulses >= 4) break;
    end
    check("mid_pulses", pulses, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_cnt", int'(fill_cnt), 0);
    check("mid_rst_mac_en", int'(mac_en), 0);
    check("mid_rst_clr", int'(mac_clr), 1);
    for (int c = 0; c < 5; c++) tick();
    check("mid_rst_no_pulses", pulses, 4);
    check("mid_rst_idle_state", int'(state), 0);
    check("mid_rst_idle_ready", int'(in_ready), 1);
    reset_model();
    load(0, 0);
    drain(-1, -1, -1, 8);
    verify(0, 7, 204);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
